// File: rtl/test_runner.sv
`default_nettype none
// ============================================================================
// Module   : test_runner
// Desc     : Host-side sequencer for the run/running/passed self-test handshake.
//            Reports the result on o_done/o_pass and the Fomu RGB LED.
// Options  : TEST_RUNNER_AUTORETRY_EN - automatic retry of failed/timed-out runs
// Revision : 1.0 - initial release
// ============================================================================
module test_runner #(
    parameter int START_DELAY = 16,
    parameter int TIMEOUT     = 1024,
    parameter int BLINK_LOG2  = 22
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_restart,
    output logic o_run,
    input  logic i_running,
    input  logic i_passed,
    output logic o_done,
    output logic o_pass,
    output logic o_led_r,
    output logic o_led_g,
    output logic o_led_b
);

    localparam int c_delay_w = $clog2(START_DELAY) + 1;
    localparam int c_tmo_w   = $clog2(TIMEOUT) + 1;
    localparam logic [c_delay_w-1:0]  c_delay_last = c_delay_w'(START_DELAY - 1);
    localparam logic [c_delay_w-1:0]  c_delay_one  = c_delay_w'(1);
    localparam logic [c_tmo_w-1:0]    c_tmo_last   = c_tmo_w'(TIMEOUT - 1);
    localparam logic [c_tmo_w-1:0]    c_tmo_one    = c_tmo_w'(1);
    localparam logic [BLINK_LOG2-1:0] c_blink_one  = BLINK_LOG2'(1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DELAY   = 3'd1,
        S_ARM     = 3'd2,
        S_RUN     = 3'd3,
        S_SETTLE  = 3'd4,
        S_PASS    = 3'd5,
        S_FAIL    = 3'd6,
        S_TIMEOUT = 3'd7
    } state_t;

    state_t                r_state;
    logic [c_delay_w-1:0]  r_delay_cnt;
    logic [c_tmo_w-1:0]    r_tmo_cnt;
    logic [BLINK_LOG2-1:0] r_blink;
    logic                  r_run;
    logic                  r_done;
    logic                  r_pass;
    logic                  r_led_r;
    logic                  r_led_g;
    logic                  r_led_b;
    logic                  w_terminal;
    logic                  w_retry;
    logic                  w_phase;

    assign w_terminal = (r_state == S_PASS) || (r_state == S_FAIL) || (r_state == S_TIMEOUT);
    assign w_phase    = r_blink[BLINK_LOG2-1];

`ifdef TEST_RUNNER_AUTORETRY_EN
    logic [1:0]            r_retries;
    logic [BLINK_LOG2-1:0] r_wait;
    logic                  w_fail_state;

    assign w_fail_state = (r_state == S_FAIL) || (r_state == S_TIMEOUT);
    // A failed state is held for one full blink period before re-arming.
    assign w_retry      = w_fail_state && (r_retries != 2'd3) && (&r_wait);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_retries <= '0;
            r_wait    <= '0;
        end else begin
            r_wait <= w_fail_state ? r_wait + c_blink_one : '0;
            if (w_terminal && i_restart) begin
                r_retries <= '0;
            end else if (w_retry) begin
                r_retries <= r_retries + 2'd1;
            end
        end
    end
`else
    assign w_retry = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_delay_cnt <= '0;
            r_tmo_cnt   <= '0;
            r_run       <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state     <= S_DELAY;
                    r_delay_cnt <= '0;
                end
                S_DELAY: begin
                    if (r_delay_cnt == c_delay_last) begin
                        r_state <= S_ARM;
                        r_run   <= 1'b1;
                    end else begin
                        r_delay_cnt <= r_delay_cnt + c_delay_one;
                    end
                end
                // running is not looked at here: the fixture may need a clock to react
                S_ARM: begin
                    r_state   <= S_RUN;
                    r_tmo_cnt <= '0;
                end
                S_RUN: begin
                    r_tmo_cnt <= r_tmo_cnt + c_tmo_one;
                    if (!i_running) begin
                        r_state <= S_SETTLE;
                    end else if (r_tmo_cnt == c_tmo_last) begin
                        r_state <= S_TIMEOUT;
                        r_run   <= 1'b0;
                        r_done  <= 1'b1;
                        r_pass  <= 1'b0;
                    end
                end
                // The fixture flags a failure one clock after running drops.
                S_SETTLE: begin
                    r_state <= i_passed ? S_PASS : S_FAIL;
                    r_done  <= 1'b1;
                    r_pass  <= i_passed;
                end
                S_PASS, S_FAIL, S_TIMEOUT: begin
                    if (i_restart || w_retry) begin
                        r_state     <= S_DELAY;
                        r_delay_cnt <= '0;
                        r_run       <= 1'b0;
                        r_done      <= 1'b0;
                        r_pass      <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_blink <= '0;
            r_led_r <= 1'b0;
            r_led_g <= 1'b0;
            r_led_b <= 1'b0;
        end else begin
            r_blink <= r_blink + c_blink_one;
            r_led_r <= 1'b0;
            r_led_g <= 1'b0;
            r_led_b <= 1'b0;
            case (r_state)
                S_ARM, S_RUN, S_SETTLE: r_led_b <= 1'b1;
                S_PASS:                 r_led_g <= 1'b1;
                S_FAIL:                 r_led_r <= w_phase;
                S_TIMEOUT: begin
                    r_led_r <= w_phase;
                    r_led_g <= w_phase;
                end
                default: ;
            endcase
        end
    end

    assign o_run   = r_run;
    assign o_done  = r_done;
    assign o_pass  = r_pass;
    assign o_led_r = r_led_r;
    assign o_led_g = r_led_g;
    assign o_led_b = r_led_b;

endmodule
`default_nettype wire

// File: tb/tb_test_runner.sv
`default_nettype none
// ============================================================================
// Module   : tb_test_runner
// Desc     : Scoreboard bench for test_runner with a behavioural fixture model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_test_runner;

    localparam int START_DELAY = 4;
    localparam int TIMEOUT     = 32;
    localparam int BLINK_LOG2  = 3;

    localparam logic [1:0] EV_RUN_RISE  = 2'd0;
    localparam logic [1:0] EV_RUN_FALL  = 2'd1;
    localparam logic [1:0] EV_DONE_RISE = 2'd2;
    localparam logic [1:0] EV_DONE_FALL = 2'd3;

    logic i_clk     = 1'b0;
    logic i_rst_n   = 1'b0;
    logic i_restart = 1'b0;
    logic i_running = 1'b0;
    logic i_passed  = 1'b1;
    logic o_run, o_done, o_pass, o_led_r, o_led_g, o_led_b;

    test_runner #(
        .START_DELAY(START_DELAY),
        .TIMEOUT    (TIMEOUT),
        .BLINK_LOG2 (BLINK_LOG2)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_restart(i_restart),
        .o_run    (o_run),
        .i_running(i_running),
        .i_passed (i_passed),
        .o_done   (o_done),
        .o_pass   (o_pass),
        .o_led_r  (o_led_r),
        .o_led_g  (o_led_g),
        .o_led_b  (o_led_b)
    );

    always #5 i_clk = ~i_clk;

    // Clock edges since reset release; edge k leaves the blink counter at k.
    int cyc = 0;
    always @(posedge i_clk) begin
        if (!i_rst_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    typedef struct packed {
        logic [1:0] kind;
        int         at;
        logic       pass;
    } ev_t;

    ev_t sb[$];
    int  checks   = 0;
    int  failures = 0;
    int  fx_len   = 10;
    bit  fx_late  = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_ev(input logic [1:0] k, input int at, input logic p);
        ev_t e;
        e.kind = k;
        e.at   = at;
        e.pass = p;
        sb.push_back(e);
    endtask

    task automatic expect_event(input logic [1:0] k, input logic p);
        ev_t e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL event: unexpected kind=%0d at cycle %0d", k, cyc);
        end else begin
            e = sb.pop_front();
            if (e.kind !== k || e.at !== cyc || (k == EV_DONE_RISE && e.pass !== p)) begin
                failures++;
                $display("FAIL event: got kind=%0d cycle=%0d pass=%0d, expected kind=%0d cycle=%0d pass=%0d",
                         k, cyc, p, e.kind, e.at, e.pass);
            end
        end
    endtask

    // Fixture: running follows run for fx_len cycles; with fx_late, passed
    // drops the cycle after running falls.
    initial begin
        int  rel;
        bit  prev;
        rel  = 0;
        prev = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_run && !prev) rel = 0;
            else if (o_run)     rel = rel + 1;
            prev      = o_run;
            i_running = o_run && (rel < fx_len);
            i_passed  = !(fx_late && o_run && (rel > fx_len));
        end
    end

    // Monitor: every edge on o_run / o_done must match the next expected event.
    initial begin
        logic m_run, m_done;
        m_run  = 1'b0;
        m_done = 1'b0;
        forever begin
            @(negedge i_clk);
            if (i_rst_n) begin
                if (o_run !== m_run)   expect_event(o_run ? EV_RUN_RISE : EV_RUN_FALL, 1'b0);
                if (o_done !== m_done) expect_event(o_done ? EV_DONE_RISE : EV_DONE_FALL, o_pass);
            end
            m_run  = o_run;
            m_done = o_done;
        end
    end

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge i_clk);
    endtask

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge i_clk);
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: %0d expected events pending after %0d cycles, required 0", name, sb.size(), budget);
            sb.delete();
        end
    endtask

    task automatic do_reset(input int len, input bit late);
        @(negedge i_clk);
        i_rst_n   = 1'b0;
        i_restart = 1'b0;
        fx_len    = len;
        fx_late   = late;
        repeat (2) @(negedge i_clk);
        chk("reset_outputs", int'({o_run, o_done, o_pass, o_led_r, o_led_g, o_led_b}), 0);
        i_rst_n = 1'b1;
    endtask

    function automatic int blink_at(input int k);
        return ((k - 1) >> (BLINK_LOG2 - 1)) & 1;
    endfunction

    // kind: 0 pass, 1 fail, 2 timeout
    task automatic check_end_leds(input string name, input int d, input int kind);
        int ph, exp;
        wait_cyc(d);
        chk({name, "_led_lag"}, int'({o_led_r, o_led_g, o_led_b}), 3'b001);
        for (int k = d + 1; k <= d + 6; k++) begin
            wait_cyc(k);
            ph  = blink_at(k);
            exp = (kind == 0) ? 3'b010 : (kind == 1) ? (ph << 2) : ((ph << 2) | (ph << 1));
            chk({name, "_led"}, int'({o_led_r, o_led_g, o_led_b}), exp);
        end
    endtask

    task automatic scenario(input string name, input int len, input bit late);
        int  a, d;
        bit  tmo;
        do_reset(len, late);
        a   = START_DELAY + 1;
        tmo = (len > TIMEOUT);
        push_ev(EV_RUN_RISE, a, 1'b0);
        if (tmo) begin
            d = a + TIMEOUT + 1;
            push_ev(EV_RUN_FALL, d, 1'b0);
            push_ev(EV_DONE_RISE, d, 1'b0);
        end else begin
            d = a + len + 2;
            push_ev(EV_DONE_RISE, d, !late);
        end
        wait_cyc(a + 2);
        chk({name, "_led_run"}, int'({o_led_r, o_led_g, o_led_b}), 3'b001);
        check_end_leds(name, d, tmo ? 2 : (late ? 1 : 0));
        drain(name, 4);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int a, d, r, t;

        scenario("pass", 10, 1'b0);
        scenario("late_fail", 10, 1'b1);
        scenario("timeout", 1000, 1'b0);
        scenario("coincident", TIMEOUT, 1'b0);
        scenario("just_timeout", TIMEOUT + 1, 1'b0);

        // Restart ignored in RUN, honoured in PASS.
        do_reset(10, 1'b0);
        a = START_DELAY + 1;
        d = a + 12;
        r = d + 2;
        push_ev(EV_RUN_RISE, a, 1'b0);
        push_ev(EV_DONE_RISE, d, 1'b1);
        push_ev(EV_RUN_FALL, r, 1'b0);
        push_ev(EV_DONE_FALL, r, 1'b0);
        push_ev(EV_RUN_RISE, r + START_DELAY, 1'b0);
        push_ev(EV_DONE_RISE, r + START_DELAY + 12, 1'b1);
        wait_cyc(a + 3);
        i_restart = 1'b1;
        @(negedge i_clk);
        i_restart = 1'b0;
        wait_cyc(r - 1);
        chk("restart_done_before", int'(o_done), 1);
        i_restart = 1'b1;
        @(negedge i_clk);
        i_restart = 1'b0;
        chk("restart_done_cleared", int'(o_done), 0);
        drain("restart", 100);

        // Reset in the middle of RUN.
        do_reset(10, 1'b0);
        push_ev(EV_RUN_RISE, START_DELAY + 1, 1'b0);
        wait_cyc(START_DELAY + 6);
        drain("midrun_pre", 2);
        chk("midrun_run_before", int'(o_run), 1);
        i_rst_n = 1'b0;
        #1;
        chk("midrun_async_run", int'(o_run), 0);
        chk("midrun_async_led", int'({o_led_r, o_led_g, o_led_b}), 0);
        scenario("after_reset", 10, 1'b0);

        for (int i = 0; i < 6; i++) begin
            scenario("random", int'($urandom_range(1, 40)), 1'($urandom_range(0, 1)));
        end

`ifdef TEST_RUNNER_AUTORETRY_EN
        // Permanently failing fixture: four attempts, then FAIL holds.
        do_reset(10, 1'b1);
        t = START_DELAY + 1;
        for (int i = 0; i < 4; i++) begin
            push_ev(EV_RUN_RISE, t, 1'b0);
            d = t + 12;
            push_ev(EV_DONE_RISE, d, 1'b0);
            if (i < 3) begin
                r = d + (1 << BLINK_LOG2);
                push_ev(EV_RUN_FALL, r, 1'b0);
                push_ev(EV_DONE_FALL, r, 1'b0);
                t = r + START_DELAY;
            end
        end
        drain("autoretry", 400);
        repeat (4 << BLINK_LOG2) @(negedge i_clk);
        chk("autoretry_final_done", int'({o_run, o_done, o_pass}), 3'b110);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
